seven_segment_counter_mux: RTL and testbench
============================================

SEVEN_SEGMENT_COUNTER_MUX -- requirements
Module: seven_segment_counter_mux

Interface
REQ-001 Parameter DIGITS, default 4: number of BCD digits and multiplexed displays; legal range 1..8.
REQ-002 Parameter COMPARE_W, default 24: prescaler and compare width.
REQ-003 Parameter COMPARE_RESET, default 10_000_000: compare value loaded at reset.
REQ-004 Parameter SCAN_DIV, default 1000: clock cycles per digit scan slot; minimum 1.
REQ-005 Parameter SEG_ACTIVE_LOW, default 0: when 1, led_out and digit_en are inverted at the outputs.
REQ-006 clk  input  1  single clock; all state is on its rising edge.
REQ-007 reset_n  input  1  asynchronous, active-low reset.
REQ-008 compare_in  input  COMPARE_W  new prescaler terminal value.
REQ-009 update_compare  input  1  load compare_in into the compare register on every cycle it is high.
REQ-010 enable  input  1  prescaler runs only while high.
REQ-011 count_down  input  1  0: count up on tick; 1: count down on tick.
REQ-012 clear  input  1  synchronous clear of prescaler and digit value.
REQ-013 led_out  output  7  segments {g,f,e,d,c,b,a} for the currently scanned digit.
REQ-014 digit_en  output  DIGITS  one-hot digit select; bit i drives display i.
REQ-015 tick  output  1  one-cycle pulse on each prescaler terminal count.
REQ-016 value_out  output  4*DIGITS  registered BCD count; digit 0 in bits [3:0].

Function
REQ-017 Compare register: loads compare_in on a clock edge where update_compare=1; otherwise holds.
REQ-018 Prescaler: increments by 1 per cycle while enable=1; holds while enable=0.
REQ-019 Terminal count: when enable=1 and prescaler >= compare register, prescaler returns to 0 and tick=1 for exactly that cycle.
REQ-020 compare=0 gives tick every enabled cycle; compare=N gives a tick period of N+1 cycles.
REQ-021 Lowering the compare below the current prescaler value gives a tick on the next enabled cycle, with no wrap through 2^COMPARE_W.
REQ-022 Tick is registered; the BCD value updates on the same edge that asserts tick, and value_out reflects it while tick is high.
REQ-023 Count up: digit 0 increments; a digit at 9 becomes 0 and carries into the next digit; all-9s wraps to all-0s.
REQ-024 Count down: digit 0 decrements; a digit at 0 becomes 9 and borrows from the next digit; all-0s wraps to all-9s.
REQ-025 Digits never hold values 10..15.
REQ-026 clear=1: prescaler=0, value=0, tick=0 on that edge; clear has priority over a coincident tick; compare register unaffected.
REQ-027 count_down is sampled on the tick cycle; changing it between ticks has no other effect.
REQ-028 Scan counter: counts 0..SCAN_DIV-1 regardless of enable; at SCAN_DIV-1 it wraps and the digit index advances; index DIGITS-1 wraps to 0.
REQ-029 digit_en is one-hot at bit[index], before SEG_ACTIVE_LOW inversion.
REQ-030 led_out decodes value_out digit[index] in the same cycle (combinational from registers).
REQ-031 Segment patterns 0..9, active-high, gfedcba: 3F,06,5B,4F,66,6D,7D,07,7F,6F.

Reset
REQ-032 reset_n=0 asynchronously sets compare=COMPARE_RESET, prescaler=0, value=0, scan counter=0, index=0, tick=0.
REQ-033 During reset: led_out=3F and digit_en=one-hot bit 0, both before inversion.
REQ-034 Reset asserted mid-count discards the count; counting restarts from 0 on the first edge after reset_n rises.

Verification
REQ-035 DIGITS=4, update_compare pulse with compare_in=4, enable=1 -> tick every 5 cycles; value_out 0000,0001,...; 0009 then 0010.
REQ-036 Count up from 9999 (compare=0) -> next tick gives 0000; then count_down=1 -> next tick gives 9999, then 9998.
REQ-037 compare=100, prescaler at 50, load compare_in=10 -> tick on the next enabled cycle, then every 11 cycles.
REQ-038 Clear asserted on a tick cycle -> value_out=0000, tick=0; enable=0 -> prescaler and value frozen while scan continues.
REQ-039 SCAN_DIV=3, value=1234 -> digit_en sequence 0001,0010,0100,1000 with led_out 66,4F,5B,06, 3 cycles each; SEG_ACTIVE_LOW=1 gives the bitwise inverse.
REQ-040 reset_n low mid-count (value=0042) -> outputs immediately at reset values; after release, compare=COMPARE_RESET, value=0000.

Source files
------------

// File: rtl/seven_segment_counter_mux.sv
// Prescaled BCD up/down counter with a time-multiplexed seven-segment driver.
// One tick per prescaler terminal count steps the BCD value; a free-running scan walks the digits.
module seven_segment_counter_mux #(
  parameter int unsigned DIGITS         = 4,
  parameter int unsigned COMPARE_W      = 24,
  parameter int unsigned COMPARE_RESET  = 10_000_000,
  parameter int unsigned SCAN_DIV       = 1000,
  parameter bit          SEG_ACTIVE_LOW = 1'b0
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [COMPARE_W-1:0]  compare_in,
  input  logic                  update_compare,
  input  logic                  enable,
  input  logic                  count_down,
  input  logic                  clear,
  output logic [6:0]            led_out,
  output logic [DIGITS-1:0]     digit_en,
  output logic                  tick,
  output logic [4*DIGITS-1:0]   value_out
);

  localparam int unsigned VALUE_W = 4 * DIGITS;
  localparam int unsigned SCAN_W  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned IDX_W   = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  logic [COMPARE_W-1:0] r_compare;
  logic [COMPARE_W-1:0] r_presc;
  logic [VALUE_W-1:0]   r_value;
  logic [VALUE_W-1:0]   w_value_nxt;
  logic                 r_tick;
  logic                 w_hit;
  logic                 w_carry;
  logic [SCAN_W-1:0]    r_scan_cnt;
  logic [IDX_W-1:0]     r_index;
  logic                 w_scan_wrap;
  logic [3:0]           w_digit;
  logic [DIGITS-1:0]    w_digit_sel;
  logic [6:0]           w_seg;

  // >= rather than == so a compare lowered below the prescaler still terminates next cycle
  assign w_hit = enable && (r_presc >= r_compare);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_compare <= COMPARE_W'(COMPARE_RESET);
    end else if (update_compare) begin
      r_compare <= compare_in;
    end
  end

  // clear wins over a coincident terminal count
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_presc <= '0;
      r_tick  <= 1'b0;
      r_value <= '0;
    end else if (clear) begin
      r_presc <= '0;
      r_tick  <= 1'b0;
      r_value <= '0;
    end else begin
      r_tick <= w_hit;
      if (w_hit) begin
        r_presc <= '0;
        r_value <= w_value_nxt;
      end else if (enable) begin
        r_presc <= r_presc + COMPARE_W'(1);
      end
    end
  end

  // Ripple carry/borrow through the BCD digits
  always_comb begin
    w_value_nxt = r_value;
    w_carry     = 1'b1;
    for (int i = 0; i < int'(DIGITS); i++) begin
      if (w_carry) begin
        if (count_down) begin
          if (r_value[4*i +: 4] == 4'd0) begin
            w_value_nxt[4*i +: 4] = 4'd9;
          end else begin
            w_value_nxt[4*i +: 4] = r_value[4*i +: 4] - 4'd1;
            w_carry               = 1'b0;
          end
        end else begin
          if (r_value[4*i +: 4] >= 4'd9) begin
            w_value_nxt[4*i +: 4] = 4'd0;
          end else begin
            w_value_nxt[4*i +: 4] = r_value[4*i +: 4] + 4'd1;
            w_carry               = 1'b0;
          end
        end
      end
    end
  end

  assign w_scan_wrap = (r_scan_cnt == SCAN_W'(SCAN_DIV - 1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_scan_cnt <= '0;
      r_index    <= '0;
    end else if (w_scan_wrap) begin
      r_scan_cnt <= '0;
      r_index    <= (r_index == IDX_W'(DIGITS - 1)) ? '0 : r_index + IDX_W'(1);
    end else begin
      r_scan_cnt <= r_scan_cnt + SCAN_W'(1);
    end
  end

  // Select the scanned digit and its enable line
  always_comb begin
    w_digit     = 4'd0;
    w_digit_sel = '0;
    for (int i = 0; i < int'(DIGITS); i++) begin
      if (r_index == IDX_W'(i)) begin
        w_digit        = r_value[4*i +: 4];
        w_digit_sel[i] = 1'b1;
      end
    end
  end

  always_comb begin
    w_seg = 7'h00;
    case (w_digit)
      4'd0:    w_seg = 7'h3F;
      4'd1:    w_seg = 7'h06;
      4'd2:    w_seg = 7'h5B;
      4'd3:    w_seg = 7'h4F;
      4'd4:    w_seg = 7'h66;
      4'd5:    w_seg = 7'h6D;
      4'd6:    w_seg = 7'h7D;
      4'd7:    w_seg = 7'h07;
      4'd8:    w_seg = 7'h7F;
      4'd9:    w_seg = 7'h6F;
      default: w_seg = 7'h00;
    endcase
  end

  assign led_out   = SEG_ACTIVE_LOW ? ~w_seg : w_seg;
  assign digit_en  = SEG_ACTIVE_LOW ? ~w_digit_sel : w_digit_sel;
  assign tick      = r_tick;
  assign value_out = r_value;

endmodule

// File: tb/tb_seven_segment_counter_mux.sv
// Directed bench for seven_segment_counter_mux: prescaler, BCD counting, clear, scan and reset.
// A second instance with inverted outputs shares all inputs.
module tb_seven_segment_counter_mux;

  logic        clk;
  logic        reset_n;
  logic [23:0] compare_in;
  logic        update_compare;
  logic        enable;
  logic        count_down;
  logic        clear;
  logic [6:0]  led_out;
  logic [3:0]  digit_en;
  logic        tick;
  logic [15:0] value_out;
  logic [6:0]  led_out_n;
  logic [3:0]  digit_en_n;
  logic        tick_n;
  logic [15:0] value_out_n;

  int n_cmp = 0;
  int n_err = 0;

  seven_segment_counter_mux #(
    .DIGITS(4), .COMPARE_W(24), .COMPARE_RESET(7), .SCAN_DIV(3), .SEG_ACTIVE_LOW(1'b0)
  ) dut (
    .clk(clk), .reset_n(reset_n), .compare_in(compare_in), .update_compare(update_compare),
    .enable(enable), .count_down(count_down), .clear(clear),
    .led_out(led_out), .digit_en(digit_en), .tick(tick), .value_out(value_out)
  );

  seven_segment_counter_mux #(
    .DIGITS(4), .COMPARE_W(24), .COMPARE_RESET(7), .SCAN_DIV(3), .SEG_ACTIVE_LOW(1'b1)
  ) dut_n (
    .clk(clk), .reset_n(reset_n), .compare_in(compare_in), .update_compare(update_compare),
    .enable(enable), .count_down(count_down), .clear(clear),
    .led_out(led_out_n), .digit_en(digit_en_n), .tick(tick_n), .value_out(value_out_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // n enabled edges until the tick; the first n-1 must be quiet
  task automatic expect_tick_after(input int n, input logic [15:0] exp_val, input string tag);
    int early;
    early = 0;
    for (int i = 0; i < n - 1; i++) begin
      step();
      if (tick) early++;
    end
    check({tag, " early"}, 32'(early), 32'd0);
    step();
    check({tag, " tick"}, 32'(tick), 32'd1);
    check({tag, " value"}, 32'(value_out), 32'(exp_val));
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, " tick"}, 32'(tick), 32'd0);
    check({tag, " value"}, 32'(value_out), 32'h0000);
    check({tag, " led"}, 32'(led_out), 32'h3F);
    check({tag, " digit_en"}, 32'(digit_en), 32'b0001);
    check({tag, " led inv"}, 32'(led_out_n), 32'h40);
    check({tag, " digit_en inv"}, 32'(digit_en_n), 32'b1110);
  endtask

  initial begin
    logic [3:0] exp_en [4];
    logic [6:0] exp_led [4];
    logic [6:0] inv_led;
    logic [3:0] inv_en;
    logic [3:0] prev_en;
    logic [3:0] en_before;
    int         ticks;
    int         found;

    exp_en[0]  = 4'b0001; exp_en[1]  = 4'b0010; exp_en[2]  = 4'b0100; exp_en[3]  = 4'b1000;
    exp_led[0] = 7'h66;   exp_led[1] = 7'h4F;   exp_led[2] = 7'h5B;   exp_led[3] = 7'h06;

    reset_n = 1'b0; compare_in = '0; update_compare = 1'b0;
    enable = 1'b0; count_down = 1'b0; clear = 1'b0;
    #2;
    check_reset_outputs("reset");
    repeat (2) @(posedge clk);
    #3 reset_n = 1'b1;
    step();
    check("post reset value", 32'(value_out), 32'h0000);

    // compare=4 -> tick every 5 cycles, decimal carry at 10
    compare_in = 24'd4; update_compare = 1'b1;
    step();
    update_compare = 1'b0; enable = 1'b1;
    expect_tick_after(5, 16'h0001, "div5 first");
    for (int k = 2; k <= 10; k++) begin
      expect_tick_after(5, (k == 10) ? 16'h0010 : 16'(k), "div5");
    end

    // compare=0: wrap both directions
    enable = 1'b0; compare_in = 24'd0; update_compare = 1'b1; clear = 1'b1;
    step();
    check("clear value", 32'(value_out), 32'h0000);
    check("clear tick", 32'(tick), 32'd0);
    update_compare = 1'b0; clear = 1'b0; count_down = 1'b1; enable = 1'b1;
    step();
    check("down wrap tick", 32'(tick), 32'd1);
    check("down wrap value", 32'(value_out), 32'h9999);
    count_down = 1'b0;
    step();
    check("up wrap value", 32'(value_out), 32'h0000);
    count_down = 1'b1;
    step();
    check("down again", 32'(value_out), 32'h9999);
    step();
    check("down 9998", 32'(value_out), 32'h9998);
    enable = 1'b0;
    step();
    check("disabled tick", 32'(tick), 32'd0);
    check("disabled value", 32'(value_out), 32'h9998);

    // lower compare below the running prescaler
    clear = 1'b1; update_compare = 1'b1; compare_in = 24'd100; count_down = 1'b0;
    step();
    clear = 1'b0; update_compare = 1'b0; enable = 1'b1;
    ticks = 0;
    repeat (50) begin
      step();
      if (tick) ticks++;
    end
    check("presc to 50 quiet", 32'(ticks), 32'd0);
    enable = 1'b0; update_compare = 1'b1; compare_in = 24'd10;
    step();
    check("load 10 no tick", 32'(tick), 32'd0);
    update_compare = 1'b0; enable = 1'b1;
    step();
    check("lowered tick", 32'(tick), 32'd1);
    check("lowered value", 32'(value_out), 32'h0001);
    expect_tick_after(11, 16'h0002, "cmp10");

    // freeze with enable low, scan keeps moving
    repeat (3) step();
    enable = 1'b0;
    en_before = digit_en;
    ticks = 0;
    repeat (5) begin
      step();
      if (tick) ticks++;
    end
    check("frozen ticks", 32'(ticks), 32'd0);
    check("frozen value", 32'(value_out), 32'h0002);
    check("scan runs frozen", 32'(en_before != digit_en), 32'd1);
    enable = 1'b1;
    expect_tick_after(8, 16'h0003, "resume");

    // clear coincident with a terminal count
    repeat (10) step();
    clear = 1'b1;
    step();
    check("clear on tick tick", 32'(tick), 32'd0);
    check("clear on tick value", 32'(value_out), 32'h0000);
    clear = 1'b0;
    expect_tick_after(11, 16'h0001, "after clear");

    // count to 1234 and watch the scan
    enable = 1'b0; clear = 1'b1; update_compare = 1'b1; compare_in = 24'd0;
    step();
    clear = 1'b0; update_compare = 1'b0; enable = 1'b1;
    repeat (1234) step();
    enable = 1'b0;
    step();
    check("value 1234", 32'(value_out), 32'h1234);
    prev_en = digit_en;
    found = 0;
    for (int i = 0; i < 16 && found == 0; i++) begin
      step();
      if (prev_en == 4'b1000 && digit_en == 4'b0001) found = 1;
      else prev_en = digit_en;
    end
    check("scan sync", 32'(found), 32'd1);
    for (int d = 0; d < 4; d++) begin
      for (int c = 0; c < 3; c++) begin
        if (d != 0 || c != 0) step();
        inv_led = ~exp_led[d];
        inv_en  = ~exp_en[d];
        check("scan digit_en", 32'(digit_en), 32'(exp_en[d]));
        check("scan led", 32'(led_out), 32'(exp_led[d]));
        check("scan led inv", 32'(led_out_n), 32'(inv_led));
        check("scan digit_en inv", 32'(digit_en_n), 32'(inv_en));
      end
    end

    // reset mid-count at 0042
    clear = 1'b1;
    step();
    clear = 1'b0; enable = 1'b1;
    repeat (42) step();
    enable = 1'b0;
    check("value 0042", 32'(value_out), 32'h0042);
    update_compare = 1'b1; compare_in = 24'd3;
    step();
    update_compare = 1'b0; enable = 1'b1;
    step();
    step();
    #2 reset_n = 1'b0;
    #1;
    check_reset_outputs("async reset");
    repeat (2) @(posedge clk);
    #3 reset_n = 1'b1;
    expect_tick_after(8, 16'h0001, "after reset");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
